// File: rtl/byte_unstriping.sv
// Four-lane to one-lane byte un-striper: each accepted 4-byte word is replayed
// as lane 0,1,2,3 bytes on consecutive cycles, with one word of look-ahead buffering.
module byte_unstriping #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in0,
  input  logic [WIDTH-1:0] data_in1,
  input  logic [WIDTH-1:0] data_in2,
  input  logic [WIDTH-1:0] data_in3,
  output logic             ready_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] data_out
);

  // Handshake: a word moves on any clock where valid_in && ready_in are both 1;
  // upstream must hold its word stable while valid_in=1 and ready_in=0.
  // The output side has no back-pressure: a byte is consumed whenever valid_out=1.

  typedef enum logic [2:0] {IDLE, L0, L1, L2, L3} state_t;

  state_t           state;
  logic [WIDTH-1:0] cur  [4];
  logic [WIDTH-1:0] pend [4];
  logic             pend_valid;
  logic [WIDTH-1:0] in_word [4];
  logic             accept;

  assign in_word[0] = data_in0;
  assign in_word[1] = data_in1;
  assign in_word[2] = data_in2;
  assign in_word[3] = data_in3;

  assign ready_in = !pend_valid;
  assign accept   = valid_in && ready_in;

  // data_out/valid_out are loaded with the byte of the state being entered,
  // so both outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pend_valid <= 1'b0;
      cur        <= '{default: '0};
      pend       <= '{default: '0};
      valid_out  <= 1'b0;
      data_out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cur       <= in_word;
            data_out  <= data_in0;
            valid_out <= 1'b1;
            state     <= L0;
          end
        end
        L0, L1, L2: begin
          if (accept) begin
            pend       <= in_word;
            pend_valid <= 1'b1;
          end
          valid_out <= 1'b1;
          case (state)
            L0:      begin data_out <= cur[1]; state <= L1; end
            L1:      begin data_out <= cur[2]; state <= L2; end
            default: begin data_out <= cur[3]; state <= L3; end
          endcase
        end
        L3: begin
          if (pend_valid) begin
            cur        <= pend;
            data_out   <= pend[0];
            pend_valid <= 1'b0;
            valid_out  <= 1'b1;
            state      <= L0;
          end else if (accept) begin
            // Bypass: an empty buffer lets the new word go straight to cur.
            cur       <= in_word;
            data_out  <= data_in0;
            valid_out <= 1'b1;
            state     <= L0;
          end else begin
            data_out  <= '0;
            valid_out <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          data_out  <= '0;
          valid_out <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/byte_unstriping.md
Name: byte_unstriping

Overview:
- Four-lane to one-lane byte un-striper; the inverse of the lane striper that distributes a byte stream round-robin over lanes 0-3.
- Accepts one 4-byte word (one byte per lane) per handshake and re-serialises it in lane order 0,1,2,3 as one byte per clock.
- Holds a one-word pending buffer so a continuous word stream sustains full output rate (1 byte/cycle) with no bubbles.

Parameters:
WIDTH  8  bits per lane byte and per output byte

Ports:
clk        in   1      single clock, all flops on posedge
reset      in   1      synchronous, active-high; clears all state on the next posedge
valid_in   in   1      data_in0..3 together form a valid word this cycle
data_in0   in   WIDTH  lane 0 byte (emitted first)
data_in1   in   WIDTH  lane 1 byte
data_in2   in   WIDTH  lane 2 byte
data_in3   in   WIDTH  lane 3 byte (emitted last)
ready_in   out  1      block can accept a word this cycle
valid_out  out  1      data_out holds a valid byte this cycle
data_out   out  WIDTH  serialised byte stream

Behaviour:
- Storage: cur[0..3] (word being emitted), pend[0..3] plus pend_valid (one queued word), and a 5-state FSM: IDLE, L0, L1, L2, L3. State Lk means lane byte k is on the output this cycle.
- Outputs are decoded only from flops, never from inputs:
  - ready_in = !pend_valid
  - valid_out = (state != IDLE)
  - data_out = cur[k] in state Lk, all-zero in IDLE
- Reset (sampled at posedge): state <= IDLE, pend_valid <= 0, cur/pend <= 0. After reset: valid_out=0, data_out=0, ready_in=1. Reset mid-word discards the in-flight and pending words with no partial flush. Reset overrides a simultaneous valid_in.
- accept = valid_in & ready_in. data_in0..3 are sampled only on accept. valid_in while ready_in=0 is ignored; upstream holds its word until accepted.
- Transitions:
  - IDLE: accept -> cur <= data_in, go L0. First byte appears the cycle after accept (latency 1). No accept -> stay IDLE.
  - L0, L1, L2: advance to L1, L2, L3 respectively. An accept in these states writes pend <= data_in and sets pend_valid=1.
  - L3, pend_valid=1: cur <= pend, clear pend_valid, go L0. No accept is possible this cycle because ready_in=0.
  - L3, pend_valid=0, accept: cur <= data_in directly (bypass), go L0.
  - L3, pend_valid=0, no accept: go IDLE.
- Steady stream with valid_in held high: one word accepted every 4 cycles, valid_out continuously 1 after the first word. ready_in pattern per 4-cycle word: 1,0,0,0.
- The block never drops or duplicates an accepted word. Byte order out is exactly in0,in1,in2,in3 per word, in word acceptance order.
- No back-pressure on the output side; the consumer must take a byte every cycle valid_out=1.

Test Plan:
1. Reset, then one word {in0..3}={11,22,33,44} with valid_in for 1 cycle -> ready_in=1 during accept; next 4 cycles valid_out=1 with data_out 11,22,33,44; then valid_out=0, data_out=00, state IDLE.
2. valid_in held high with words W0=01..04, W1=05..08, W2=09..0C -> data_out 01..0C on 12 consecutive cycles, no gap. ready_in is 0 from the cycle after W1 is accepted until L3 of W0.
3. Backpressure: in cycle after W1 is pended, drive a different word AA.. with valid_in while ready_in=0 -> AA never appears on data_out; the held W2 is accepted when ready_in returns to 1.
4. Bypass path: accept W0, then assert W1 only during W0's L3 cycle (pend empty) -> W1 bytes follow W0 bytes with no idle cycle.
5. Assert reset during L2 of W0 with a word pending -> the next cycle has valid_out=0, ready_in=1, data_out=00. A fresh word after reset emits correctly with no stale bytes.
6. Reset and valid_in in the same cycle -> the word is not accepted; the block stays IDLE.
